csr_trap_unit: RTL
==================

# csr_trap_unit

Machine-mode trap sequencer sitting between the core's exception/interrupt sources and the CSR register file. It accepts one trap or `mret` request at a time, sequences the required writes to `mepc`/`mcause`/`mtval`/`mstatus` through the CSR file's write port, and reads `mtvec`/`mepc` back through its read port. It then issues a one-cycle PC redirect to the fetch stage. The core stalls on `oBusy` while a sequence is in flight.

## Interface
- `XLEN`, 32, data/address width
- `IRQ_CAUSE`, 5'd11, cause code used for the external interrupt

Ports:
- `iCLK`  in  1  clock, rising-edge
- `iRST_N`  in  1  asynchronous reset, active-low
- `iExcReq`  in  1  synchronous exception pulse (sampled only in IDLE)
- `iExcCause`  in  5  exception cause code
- `iExcTval`  in  XLEN  faulting address/instruction (e.g. misaligned address)
- `iPC`  in  XLEN  PC to save in `mepc` (faulting PC for exceptions, next PC for interrupts)
- `iMret`  in  1  `mret` retire pulse
- `iIrq`  in  1  level-sensitive external interrupt
- `oCSRWrite`  out  1  CSR write strobe
- `oCSRWAddr`  out  12  CSR write address
- `oCSRWData`  out  XLEN  CSR write data
- `oCSRRAddr`  out  12  CSR read address
- `iCSRRData`  in  XLEN  combinational read data for `oCSRRAddr`
- `oRedirect`  out  1  one-cycle PC redirect strobe
- `oTarget`  out  XLEN  redirect PC, valid when `oRedirect`=1
- `oBusy`  out  1  sequence in flight; the core must stall
- `oMIE`  out  1  current `mstatus.MIE`

## Operation
- CSR addresses: `mstatus` 0x300, `mtvec` 0x305, `mepc` 0x341, `mcause` 0x342, `mtval` 0x343.
- Internal state: `MIE` and `MPIE` bits, plus latched PC, cause, tval and the `is_irq` flag.
- FSM states: IDLE, T_EPC, T_CAUSE, T_TVAL, T_REDIR, R_READ, R_REDIR.
- IDLE acceptance priority on a rising edge:
  1. `iExcReq` → T_EPC; latch `iPC`, `iExcCause`, `iExcTval`; `is_irq`=0.
  2. Else `iMret` → R_READ.
  3. Else `iIrq` and `MIE`=1 → T_EPC; latch `iPC`; cause=`IRQ_CAUSE`; tval=0; `is_irq`=1.
  4. Else stay in IDLE.
- Requests arriving outside IDLE are ignored; the core guarantees it holds them off while `oBusy`=1.
- T_EPC: write `mepc` = {latched PC[31:2], 2'b00}.
- T_CAUSE: write `mcause` = {`is_irq`, 26'b0, cause[4:0]}.
- T_TVAL: write `mtval` = tval. Drive `oCSRRAddr`=0x305 and register `iCSRRData` as the `mtvec` value.
- T_REDIR:
  - Write `mstatus` with MPIE←MIE, MIE←0, all other bits 0, MPP=2'b11 (bits 12:11).
  - Assert `oRedirect` with `oTarget` = {mtvec[31:2], 2'b00}.
  - Update internal MIE/MPIE at the same edge.
- R_READ: drive `oCSRRAddr`=0x341 and register `iCSRRData`. Write `mstatus` with MIE←MPIE, MPIE←1; update internal bits at the same edge.
- R_REDIR: `oRedirect`=1, `oTarget` = registered `mepc`.
- `oCSRWrite` is 1 only in T_EPC, T_CAUSE, T_TVAL, T_REDIR and R_READ.
- When not in a read state, `oCSRRAddr` is 0x300.
- `oBusy` = (state ≠ IDLE), registered.

## Timing
- All outputs are registered. Reset value of every output is 0; internal `MIE`=0, `MPIE`=0, FSM in IDLE.
- Trap sequence: request sampled at edge 0. `oCSRWrite` is high during cycles 1–4. `oRedirect` is high only during cycle 4. FSM returns to IDLE at edge 5, so a new request is accepted at edge 5.
- `mret` sequence: sampled at edge 0; R_READ in cycle 1; `oRedirect` in cycle 2; IDLE at edge 3.
- Simultaneous `iExcReq`, `iMret` and `iIrq`: exception wins. The others are dropped; `iIrq` is retaken later if still high and MIE=1.
- An interrupt cannot nest: MIE=0 after T_REDIR until `mret` restores it.
- Reset asserted mid-sequence aborts immediately: no further CSR writes, FSM to IDLE, outputs 0.
- `oCSRWData` reflects the pre-update MIE/MPIE; there is no read-after-write hazard because each state is a distinct cycle.

## Configuration
- `CSR_VECTORED_EN` defined:
  - T_REDIR honours `mtvec[1:0]`. When mode=2'b01 and `is_irq`=1, `oTarget` = {mtvec[31:2], 2'b00} + 4·cause.
  - Exceptions always use the base address.
- Not defined: mode bits are ignored and every trap goes to the base address. Vector arithmetic is XLEN-wide and wraps modulo 2^32.

## Test plan
- Reset low mid-T_CAUSE → all outputs 0 next cycle; no `mtval` write; exception accepted 1 cycle after reset release.
- `iExcReq` with cause=4, PC=0x0000_0104, tval=0x0000_1003, `mtvec`=0x0000_2000 → writes in cycles 1–4:
  - `mepc`=0x104
  - `mcause`=0x4
  - `mtval`=0x1003
  - `mstatus`=0x1800
  
  Then `oRedirect`=1 with `oTarget`=0x2000 in cycle 4.
- MIE=1, `iIrq`=1, PC=0x200 → `mcause`=0x8000_000B, `mtval`=0, `mstatus`=0x1880, `oMIE`=0 after redirect. With `CSR_VECTORED_EN` and `mtvec`=0x2001, `oTarget`=0x202C; without the macro, 0x2000.
- `iMret` with `mepc`=0x204, MPIE=1 → `mstatus` write 0x88 in cycle 1; `oRedirect`/`oTarget`=0x204 in cycle 2; `oMIE`=1.
- `iExcReq`, `iMret` and `iIrq` all high in one IDLE cycle → exception sequence only; `iIrq` ignored while `oBusy`=1 and MIE=0.

Source files
------------

// File: rtl/csr_trap_unit_if.sv
// csr_trap_unit_if: CSR register-file port between the trap sequencer (master) and the CSR file (slave).
interface csr_trap_unit_if #(parameter int XLEN = 32);
  logic            oCSRWrite;
  logic [11:0]     oCSRWAddr;
  logic [XLEN-1:0] oCSRWData;
  logic [11:0]     oCSRRAddr;
  logic [XLEN-1:0] iCSRRData;
  modport master (output oCSRWrite, oCSRWAddr, oCSRWData, oCSRRAddr, input iCSRRData);
  modport slave  (input oCSRWrite, oCSRWAddr, oCSRWData, oCSRRAddr, output iCSRRData);
endinterface

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: M-mode trap/mret sequencer writing mepc/mcause/mtval/mstatus and redirecting fetch.
// Define CSR_VECTORED_EN to vector interrupts through mtvec mode 2'b01.
module csr_trap_unit #(
  parameter int         XLEN      = 32,
  parameter logic [4:0] IRQ_CAUSE = 5'd11
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iExcReq,
  input  logic [4:0]      iExcCause,
  input  logic [XLEN-1:0] iExcTval,
  input  logic [XLEN-1:0] iPC,
  input  logic            iMret,
  input  logic            iIrq,
  csr_trap_unit_if.master csr,
  output logic            oRedirect,
  output logic [XLEN-1:0] oTarget,
  output logic            oBusy,
  output logic            oMIE
);
  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;
  localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};
  typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_REDIR, R_READ, R_REDIR} state_t;
  state_t state, stateNext;
  logic [XLEN-1:0] pcQ, tvalQ;
  logic [4:0] causeQ;
  logic isIrqQ, mie, mpie;
  logic canAccept, takeExc, takeMret, takeIrq;
  logic wrNext, redirNext;
  logic [11:0] wAddrNext, rAddrNext;
  logic [XLEN-1:0] wDataNext, targetNext, trapStatus, mretStatus, trapBase, trapTarget;
  // Outputs are registered decodes of the current state, so oBusy trails the FSM by a cycle;
  // gating acceptance on oBusy keeps a new request out until the previous redirect has retired.
  always_comb begin
    canAccept = state == IDLE && !oBusy;
    takeExc   = canAccept && iExcReq;
    takeMret  = canAccept && !iExcReq && iMret;
    takeIrq   = canAccept && !iExcReq && !iMret && iIrq && mie;
    stateNext = state;
    case (state)
      IDLE:    stateNext = (takeExc || takeIrq) ? T_EPC : takeMret ? R_READ : IDLE;
      T_EPC:   stateNext = T_CAUSE;
      T_CAUSE: stateNext = T_TVAL;
      T_TVAL:  stateNext = T_REDIR;
      R_READ:  stateNext = R_REDIR;
      default: stateNext = IDLE;
    endcase
  end
  always_comb begin
    trapStatus        = '0;
    trapStatus[12:11] = 2'b11;
    trapStatus[7]     = mie;
    mretStatus        = '0;
    mretStatus[7]     = 1'b1;
    mretStatus[3]     = mpie;
    trapBase          = csr.iCSRRData & ALIGN;
`ifdef CSR_VECTORED_EN
    trapTarget = (csr.iCSRRData[1:0] == 2'b01 && isIrqQ) ? trapBase + {{(XLEN-7){1'b0}}, causeQ, 2'b00} : trapBase;
`else
    trapTarget = trapBase;
`endif
    wrNext     = state inside {T_EPC, T_CAUSE, T_TVAL, T_REDIR, R_READ};
    wAddrNext  = state == T_EPC ? MEPC : state == T_CAUSE ? MCAUSE : state == T_TVAL ? MTVAL : wrNext ? MSTATUS : 12'h000;
    wDataNext  = state == T_EPC   ? pcQ & ALIGN
               : state == T_CAUSE ? {isIrqQ, {(XLEN-6){1'b0}}, causeQ}
               : state == T_TVAL  ? tvalQ
               : state == T_REDIR ? trapStatus
               : state == R_READ  ? mretStatus : '0;
    rAddrNext  = state == T_TVAL ? MTVEC : state == R_READ ? MEPC : MSTATUS;
    redirNext  = state == T_REDIR || state == R_REDIR;
    targetNext = state == T_REDIR ? trapTarget : state == R_REDIR ? csr.iCSRRData : '0;
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state         <= IDLE;
      pcQ           <= '0;
      tvalQ         <= '0;
      causeQ        <= '0;
      isIrqQ        <= 1'b0;
      mie           <= 1'b0;
      mpie          <= 1'b0;
      csr.oCSRWrite <= 1'b0;
      csr.oCSRWAddr <= '0;
      csr.oCSRWData <= '0;
      csr.oCSRRAddr <= '0;
      oRedirect     <= 1'b0;
      oTarget       <= '0;
      oBusy         <= 1'b0;
      oMIE          <= 1'b0;
    end else begin
      state <= stateNext;
      if (takeExc) begin
        pcQ    <= iPC;
        causeQ <= iExcCause;
        tvalQ  <= iExcTval;
        isIrqQ <= 1'b0;
      end else if (takeIrq) begin
        pcQ    <= iPC;
        causeQ <= IRQ_CAUSE;
        tvalQ  <= '0;
        isIrqQ <= 1'b1;
      end
      if (state == T_REDIR) begin
        mpie <= mie;
        mie  <= 1'b0;
      end else if (state == R_READ) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
      csr.oCSRWrite <= wrNext;
      csr.oCSRWAddr <= wAddrNext;
      csr.oCSRWData <= wDataNext;
      csr.oCSRRAddr <= rAddrNext;
      oRedirect     <= redirNext;
      oTarget       <= targetNext;
      oBusy         <= state != IDLE;
      oMIE          <= mie;
    end
  end
endmodule
